// File: rtl/wish_pack_flex.sv
// Packs narrow Wishbone-pipelined beats into NUM_PACK-lane words with runtime ratio,
// early flush on packet end, output back-pressure and outstanding-ack tracking.
// Optional lane-valid mask d_sel_o is built when WISH_PACK_FLEX_SEL_EN is defined.
//
// Handshake: a source beat is accepted when s_cyc_i & s_stb_i & ~s_stall_o; an output
// word transfers when d_stb_o & ~d_stall_i, and d_dat_o/d_tgc_o/d_sel_o hold while stalled.
module wish_pack_flex #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_PACK        = 4,
  parameter int TGC_WIDTH       = 2,
  parameter int LITTLE_ENDIAN   = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [$clog2(NUM_PACK+1)-1:0]  cfg_num_i,
  input  logic                           s_cyc_i,
  input  logic                           s_stb_i,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           s_stall_o,
  output logic                           s_ack_o,
  output logic                           d_cyc_o,
  output logic                           d_stb_o,
  output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
`ifdef WISH_PACK_FLEX_SEL_EN
  output logic [NUM_PACK-1:0]            d_sel_o,
`endif
  input  logic                           d_stall_i,
  input  logic                           d_ack_i,
  output logic [0:0]                     dbg_state_o
);

  localparam int CW = $clog2(NUM_PACK + 1);
  // One spare count: a word already in the output register may still leave at the limit.
  localparam int OW = $clog2(MAX_OUTSTANDING + 2);
  localparam logic [CW-1:0] NP    = CW'(NUM_PACK);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0]                     state;
  logic [CW-1:0]                  slot;
  logic [CW-1:0]                  cur_num;
  logic [CW-1:0]                  eff_cfg;
  logic [CW-1:0]                  num_now;
  logic [DATA_WIDTH*NUM_PACK-1:0] acc_dat;
  logic [DATA_WIDTH*NUM_PACK-1:0] word_dat;
  logic [TGC_WIDTH-1:0]           word_tgc;
  logic [TGC_WIDTH-1:0]           beat_tgc;
  logic [TGC_WIDTH-1:0]           out_tgc;
  logic [OW-1:0]                  out_cnt;
  logic                           accept;
  logic                           complete;
  logic                           last_beat;
  logic                           out_xfer;
  logic                           ack_dec;
  int                             lane;

  assign s_stall_o   = (d_stb_o & d_stall_i) | (out_cnt >= MAX_O);
  assign d_cyc_o     = d_stb_o | (out_cnt != '0);
  assign dbg_state_o = state;
  assign accept      = s_cyc_i & s_stb_i & ~s_stall_o;
  assign last_beat   = s_tgc_i[1];
  assign out_xfer    = d_stb_o & ~d_stall_i;
  assign ack_dec     = d_ack_i & (out_cnt != '0);

  always_comb begin
    eff_cfg  = ((cfg_num_i == '0) || (cfg_num_i > NP)) ? NP : cfg_num_i;
    num_now  = (state == ST_IDLE) ? eff_cfg : cur_num;
    complete = accept & ((slot == num_now - CW'(1)) | last_beat);
    lane     = (LITTLE_ENDIAN != 0) ? int'(slot) : NUM_PACK - 1 - int'(slot);
    word_dat = (state == ST_ACC) ? acc_dat : '0;
    for (int l = 0; l < NUM_PACK; l++) begin
      if (l == lane) word_dat[l*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
    end
    // Only the opening beat of a packet may carry the first flag into a word.
    beat_tgc    = s_tgc_i;
    beat_tgc[0] = (state == ST_IDLE) & s_tgc_i[0];
    out_tgc     = (slot == '0) ? beat_tgc : word_tgc;
    out_tgc[1]  = last_beat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      slot     <= '0;
      cur_num  <= '0;
      acc_dat  <= '0;
      word_tgc <= '0;
      s_ack_o  <= 1'b0;
      d_stb_o  <= 1'b0;
      d_dat_o  <= '0;
      d_tgc_o  <= '0;
      out_cnt  <= '0;
    end else begin
      s_ack_o <= accept;
      if (accept) begin
        if (state == ST_IDLE) cur_num <= eff_cfg;
        if (slot == '0) word_tgc <= beat_tgc;
        if (complete) begin
          slot    <= '0;
          acc_dat <= '0;
          state   <= last_beat ? ST_IDLE : ST_ACC;
        end else begin
          slot    <= slot + CW'(1);
          acc_dat <= word_dat;
          state   <= ST_ACC;
        end
      end else if ((state == ST_ACC) && !s_cyc_i) begin
        state   <= ST_IDLE;
        slot    <= '0;
        acc_dat <= '0;
      end

      // A completing word may reload the register in the same cycle it drains.
      if (complete) begin
        d_stb_o <= 1'b1;
        d_dat_o <= word_dat;
        d_tgc_o <= out_tgc;
      end else if (out_xfer) begin
        d_stb_o <= 1'b0;
      end

      case ({out_xfer, ack_dec})
        2'b10:   out_cnt <= out_cnt + OW'(1);
        2'b01:   out_cnt <= out_cnt - OW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

`ifdef WISH_PACK_FLEX_SEL_EN
  logic [NUM_PACK-1:0] acc_sel;
  logic [NUM_PACK-1:0] word_sel;

  always_comb begin
    word_sel = (state == ST_ACC) ? acc_sel : '0;
    for (int l = 0; l < NUM_PACK; l++) begin
      if (l == lane) word_sel[l] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_sel <= '0;
      d_sel_o <= '0;
    end else begin
      if (accept) acc_sel <= complete ? '0 : word_sel;
      else if ((state == ST_ACC) && !s_cyc_i) acc_sel <= '0;
      if (complete) d_sel_o <= word_sel;
    end
  end
`endif

endmodule

// File: tb/tb_wish_pack_flex.sv
// Self-checking bench for wish_pack_flex: a big-endian and a little-endian instance share
// stimulus; a packing model pushes expected words that a monitor pops on each output transfer.
module tb_wish_pack_flex;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  cfg_num = 3'd4;
  logic        s_cyc = 1'b0;
  logic        s_stb = 1'b0;
  logic [7:0]  s_dat = '0;
  logic [1:0]  s_tgc = '0;
  logic        d_stall = 1'b0;
  logic        d_ack = 1'b1;

  logic        s_stall_be, s_ack_be, d_cyc_be, d_stb_be;
  logic [31:0] d_dat_be;
  logic [1:0]  d_tgc_be;
  logic [0:0]  state_be;
  logic        s_stall_le, s_ack_le, d_cyc_le, d_stb_le;
  logic [31:0] d_dat_le;
  logic [1:0]  d_tgc_le;
  logic [0:0]  state_le;
`ifdef WISH_PACK_FLEX_SEL_EN
  logic [3:0]  d_sel_be, d_sel_le;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int acc_cnt = 0;

  logic [31:0] exp_be_q[$];
  logic [31:0] exp_le_q[$];
  logic [1:0]  exp_tgc_q[$];
  logic [3:0]  exp_sel_be_q[$];
  logic [3:0]  exp_sel_le_q[$];

  bit          m_idle = 1'b1;
  int          m_cur = 4;
  int          m_slot = 0;
  bit          m_first = 1'b0;
  logic [7:0]  m_beats[4];

  wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0),
                   .MAX_OUTSTANDING(2)) u_be (
    .clk_i(clk), .rst_i(rst_i), .cfg_num_i(cfg_num),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
    .s_stall_o(s_stall_be), .s_ack_o(s_ack_be),
    .d_cyc_o(d_cyc_be), .d_stb_o(d_stb_be), .d_dat_o(d_dat_be), .d_tgc_o(d_tgc_be),
`ifdef WISH_PACK_FLEX_SEL_EN
    .d_sel_o(d_sel_be),
`endif
    .d_stall_i(d_stall), .d_ack_i(d_ack), .dbg_state_o(state_be)
  );

  wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1),
                   .MAX_OUTSTANDING(2)) u_le (
    .clk_i(clk), .rst_i(rst_i), .cfg_num_i(cfg_num),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
    .s_stall_o(s_stall_le), .s_ack_o(s_ack_le),
    .d_cyc_o(d_cyc_le), .d_stb_o(d_stb_le), .d_dat_o(d_dat_le), .d_tgc_o(d_tgc_le),
`ifdef WISH_PACK_FLEX_SEL_EN
    .d_sel_o(d_sel_le),
`endif
    .d_stall_i(d_stall), .d_ack_i(d_ack), .dbg_state_o(state_le)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference packer: collects accepted beats and emits both lane orders on completion.
  task automatic model_accept(input logic [7:0] d, input logic [1:0] t);
    logic [31:0] be, le;
    logic [3:0]  sb, sl;
    if (m_idle) begin
      m_cur  = (cfg_num == 3'd0 || cfg_num > 3'd4) ? 4 : int'(cfg_num);
      m_slot = 0;
    end
    if (m_slot == 0) m_first = m_idle ? t[0] : 1'b0;
    m_idle = 1'b0;
    m_beats[m_slot] = d;
    if (m_slot == m_cur - 1 || t[1]) begin
      be = '0; le = '0; sb = '0; sl = '0;
      for (int k = 0; k <= m_slot; k++) begin
        be[(3-k)*8 +: 8] = m_beats[k];
        le[k*8 +: 8]     = m_beats[k];
        sb[3-k]          = 1'b1;
        sl[k]            = 1'b1;
      end
      exp_be_q.push_back(be);
      exp_le_q.push_back(le);
      exp_tgc_q.push_back({t[1], m_first});
      exp_sel_be_q.push_back(sb);
      exp_sel_le_q.push_back(sl);
      m_slot = 0;
      if (t[1]) m_idle = 1'b1;
    end else begin
      m_slot++;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [1:0] t);
    logic st;
    bit   done;
    done  = 1'b0;
    s_cyc = 1'b1;
    s_stb = 1'b1;
    s_dat = d;
    s_tgc = t;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      st = s_stall_be;
      @(posedge clk);
      if (!st) begin
        done = 1'b1;
        acc_cnt++;
        model_accept(d, t);
      end
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    #1;
    s_stb = 1'b0;
  endtask

  task automatic drop_cyc();
    s_cyc  = 1'b0;
    m_idle = 1'b1;
    idle_cycles(1);
    s_cyc  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (s_ack_be) ack_cnt++;
      if (d_stb_be && !d_stall) begin
        if (exp_be_q.size() == 0) begin
          check("spurious_word", {32'd0, d_dat_be}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("word_be", {32'd0, d_dat_be}, {32'd0, exp_be_q.pop_front()});
          check("word_le", {32'd0, d_dat_le}, {32'd0, exp_le_q.pop_front()});
          check("word_tgc", {62'd0, d_tgc_be}, {62'd0, exp_tgc_q.pop_front()});
`ifdef WISH_PACK_FLEX_SEL_EN
          check("sel_be", {60'd0, d_sel_be}, {60'd0, exp_sel_be_q.pop_front()});
          check("sel_le", {60'd0, d_sel_le}, {60'd0, exp_sel_le_q.pop_front()});
`else
          void'(exp_sel_be_q.pop_front());
          void'(exp_sel_le_q.pop_front());
`endif
        end
      end
    end
  end

  initial begin
    int ack_before;
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stb", {63'd0, d_stb_be}, 64'd0);
    check("rst_cyc", {63'd0, d_cyc_be}, 64'd0);
    check("rst_ack", {63'd0, s_ack_be}, 64'd0);
    check("rst_stall", {63'd0, s_stall_be}, 64'd0);
    check("rst_dat", {32'd0, d_dat_be}, 64'd0);
    check("rst_state", {63'd0, state_be}, 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    s_cyc = 1'b1;
    idle_cycles(2);

    // Full four-lane packet.
    cfg_num = 3'd4;
    ack_before = ack_cnt;
    send_beat(8'h11, 2'b01);
    send_beat(8'h22, 2'b00);
    send_beat(8'h33, 2'b00);
    send_beat(8'h44, 2'b10);
    @(negedge clk);
    check("t1_latency", {63'd0, d_stb_be}, 64'd1);
    check("t1_tgc", {62'd0, d_tgc_be}, 64'd3);
    idle_cycles(1);
    check("t1_acks", 64'(ack_cnt - ack_before), 64'd4);
    check("t1_idle", {63'd0, state_be}, 64'd0);

    // Ratio 2, ratio change mid-packet must not take effect.
    cfg_num = 3'd2;
    send_beat(8'hA1, 2'b01);
    cfg_num = 3'd4;
    send_beat(8'hB2, 2'b00);
    send_beat(8'hC3, 2'b00);
    send_beat(8'hD4, 2'b10);
    idle_cycles(2);

    // Early flush of a partial word.
    cfg_num = 3'd4;
    send_beat(8'h01, 2'b01);
    send_beat(8'h02, 2'b00);
    send_beat(8'h03, 2'b10);
    idle_cycles(2);
    check("t3_idle", {63'd0, state_be}, 64'd0);

    // Output stall holds the word and blocks the source.
    d_stall = 1'b1;
    send_beat(8'hA0, 2'b01);
    send_beat(8'hA1, 2'b00);
    send_beat(8'hA2, 2'b00);
    send_beat(8'hA3, 2'b00);
    fork
      send_beat(8'h55, 2'b00);
      begin
        repeat (5) begin
          @(negedge clk);
          check("t4_hold", {32'd0, d_dat_be}, 64'hA0A1A2A3);
          check("t4_stall", {63'd0, s_stall_be}, 64'd1);
        end
        @(posedge clk);
        #1 d_stall = 1'b0;
      end
    join
    send_beat(8'h66, 2'b00);
    send_beat(8'h77, 2'b00);
    send_beat(8'h88, 2'b10);
    idle_cycles(3);

    // Outstanding limit of two with acks withheld.
    d_ack   = 1'b0;
    cfg_num = 3'd1;
    send_beat(8'h5A, 2'b11);
    send_beat(8'h5B, 2'b11);
    idle_cycles(2);
    @(negedge clk);
    check("t5_stall_full", {63'd0, s_stall_be}, 64'd1);
    check("t5_cyc_full", {63'd0, d_cyc_be}, 64'd1);
    idle_cycles(1);
    d_ack = 1'b1;
    idle_cycles(1);
    d_ack = 1'b0;
    @(negedge clk);
    check("t5_stall_rel", {63'd0, s_stall_be}, 64'd0);
    check("t5_cyc_one", {63'd0, d_cyc_be}, 64'd1);
    idle_cycles(1);
    d_ack = 1'b1;
    idle_cycles(1);
    @(negedge clk);
    check("t5_cyc_zero", {63'd0, d_cyc_be}, 64'd0);
    idle_cycles(1);

    // Cycle drop discards partial beats; the next packet starts clean.
    cfg_num = 3'd4;
    send_beat(8'h91, 2'b01);
    send_beat(8'h92, 2'b00);
    drop_cyc();
    check("t6_drop_idle", {63'd0, state_be}, 64'd0);
    send_beat(8'hB1, 2'b01);
    send_beat(8'hB2, 2'b00);
    send_beat(8'hB3, 2'b00);
    send_beat(8'hB4, 2'b10);
    idle_cycles(3);

    // Reset during a stalled output word.
    d_stall = 1'b1;
    cfg_num = 3'd1;
    send_beat(8'hEE, 2'b11);
    idle_cycles(2);
    rst_i = 1'b1;
    exp_be_q.delete(); exp_le_q.delete(); exp_tgc_q.delete();
    exp_sel_be_q.delete(); exp_sel_le_q.delete();
    m_idle = 1'b1;
    idle_cycles(1);
    @(negedge clk);
    check("t6_rst_stb", {63'd0, d_stb_be}, 64'd0);
    check("t6_rst_cyc", {63'd0, d_cyc_be}, 64'd0);
    check("t6_rst_stall", {63'd0, s_stall_be}, 64'd0);
    check("t6_rst_dat", {32'd0, d_dat_be}, 64'd0);
    check("t6_rst_tgc", {62'd0, d_tgc_be}, 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    d_stall = 1'b0;
    idle_cycles(1);

    // Random packets with random ratios, including out-of-range values.
    for (int p = 0; p < 8; p++) begin
      cfg_num = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send_beat(8'($urandom_range(0, 255)), {b == len - 1, b == 0});
      end
    end

    for (int i = 0; i < 50 && exp_be_q.size() != 0; i++) idle_cycles(1);
    idle_cycles(2);
    check("drain", 64'(exp_be_q.size()), 64'd0);
    check("ack_total", 64'(ack_cnt), 64'(acc_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wish_pack_flex.md
Name: wish_pack_flex

Overview:
- Packs a stream of DATA_WIDTH-bit Wishbone-pipelined beats into NUM_PACK-lane wide words.
- Successor to wish_pack, with these additions:
  - runtime pack ratio;
  - early flush of a partial word on packet end, with a lane-valid mask;
  - output back-pressure (d_stall_i);
  - outstanding-ack tracking that drives d_cyc_o.
- Sits between a narrow stream producer (e.g. wish_readIntegers) and a wide consumer (e.g. wish_writeIntegers).

Parameters:
- DATA_WIDTH, 8: bits per input beat and per output lane.
- NUM_PACK, 4: maximum lanes per output word; must be at least 1.
- TGC_WIDTH, 2: tag width. Bit0 = first, bit1 = last; bits 2 and up pass through from the first beat of each output word. Must be at least 2.
- LITTLE_ENDIAN, 0: 0 = first beat in the MS lane (lane NUM_PACK-1). 1 = first beat in lane 0.
- MAX_OUTSTANDING, 4: depth of the unacked output-beat counter.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_num_i  in  $clog2(NUM_PACK+1)  lanes per word. Sampled at packet start. 0 or greater than NUM_PACK is treated as NUM_PACK.
- s_cyc_i  in  1  source cycle.
- s_stb_i  in  1  source strobe.
- s_dat_i  in  DATA_WIDTH  source data.
- s_tgc_i  in  TGC_WIDTH  source tag.
- s_stall_o  out  1  source stall.
- s_ack_o  out  1  source ack, registered.
- d_cyc_o  out  1  destination cycle.
- d_stb_o  out  1  destination strobe (output word valid).
- d_dat_o  out  DATA_WIDTH*NUM_PACK  packed word.
- d_tgc_o  out  TGC_WIDTH  output tag.
- d_sel_o  out  NUM_PACK  lane-valid mask. Present only with the optional feature.
- d_stall_i  in  1  destination stall.
- d_ack_i  in  1  destination ack.

Behaviour:
- Transfer rules:
  - Input accept: s_cyc_i & s_stb_i & ~s_stall_o.
  - Output transfer: d_stb_o & ~d_stall_i.
- Reset: all outputs 0; FSM in IDLE; lane counter 0; outstanding counter 0; output register empty.
- State IDLE:
  - On accept: latch cur_num from cfg_num_i, store the beat in lane slot 0, record the first flag, go to ACC.
  - If the beat also completes a word (cur_num=1, or s_tgc_i[1]=1), it moves straight to the output register.
- State ACC:
  - Each accept fills the next slot.
  - The word completes when slot index = cur_num-1, or when the accepted beat has tgc[1]=1.
  - On completion:
    - If tgc[1]=1, go to IDLE.
    - Otherwise stay in ACC, with the slot counter cleared and cur_num unchanged.
- Slot-to-lane mapping:
  - LITTLE_ENDIAN=0: slot k goes to lane NUM_PACK-1-k.
  - LITTLE_ENDIAN=1: slot k goes to lane k.
  - Unfilled lanes are driven to 0.
- Output register:
  - Loaded on the clock edge where a word completes. d_stb_o=1 the next cycle, so latency from the completing beat is 1 cycle.
  - d_tgc_o[0] = first flag of the packet's first word. d_tgc_o[1] = last flag.
  - Held stable while d_stall_i=1.
  - Emptying and reloading in the same cycle is allowed (back-to-back words, no bubble).
- s_stall_o = d_stb_o & d_stall_i, or outstanding counter = MAX_OUTSTANDING.
- s_ack_o = 1 exactly one cycle after each accept.
- Outstanding counter:
  - +1 per output transfer, -1 per d_ack_i. Both in the same cycle leaves it unchanged.
  - d_ack_i with the counter at 0 is ignored.
- d_cyc_o = d_stb_o, or outstanding counter != 0.
- s_cyc_i falling while in ACC:
  - The partially filled slots are discarded and the FSM returns to IDLE.
  - The output register and the outstanding counter are unaffected.
- rst_i asserted mid-packet or mid-stall: everything returns to reset values on that edge. In-flight data is lost.

Optional Feature:
- Macro: WISH_PACK_FLEX_SEL_EN.
- Defined: the d_sel_o port exists. Bit L=1 if lane L holds a valid beat; it is registered together with d_dat_o.
- Undefined: the port is absent. Partial words are zero-padded only, and the consumer relies on the tgc last flag.

Test Plan:
1. NUM_PACK=4, LE=0, cfg_num=4. Feed beats 0x11,0x22,0x33,0x44, with tgc=01 on the first beat and 10 on the last, no stall -> d_dat_o=0x11223344, d_tgc_o=11, d_stb_o one cycle after the 0x44 accept, 4 s_ack_o pulses.
2. cfg_num=2, LE=1. Feed 0xA1,0xB2,0xC3,0xD4 with last on 0xD4 -> words 0x0000B2A1 (tgc=01), then 0x0000D4C3 (tgc=10). With the feature: sel=0011 for both words.
3. cfg_num=4, LE=0. Feed 0x01,0x02,0x03 with last on 0x03 -> 0x01020300, tgc=11, sel=1110. FSM back in IDLE.
4. Hold d_stall_i=1 for 5 cycles while a word is ready -> d_dat_o stable, s_stall_o=1, no accepts. After release, the next word follows with no lost beats.
5. MAX_OUTSTANDING=2, d_ack_i held 0 -> after 2 output transfers s_stall_o=1 and d_cyc_o=1. One d_ack_i pulse -> count 1, stall releases. Counter reaches 0 -> d_cyc_o=0.
6. Drop s_cyc_i after 2 beats, then assert rst_i during a stalled output -> partial beats discarded; all outputs 0 on the edge after reset.
